// File: rtl/pio_input_conditioner.sv
// pio_input_conditioner: per-channel 2-flop synchroniser, counter debouncer and edge detector.
// Optional per-channel glitch counters are enabled by defining PIO_COND_GLITCH_CNT_EN.
module pio_input_conditioner #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic [WIDTH-1:0]   raw_i,
   input  logic               clr_i,
   output logic [WIDTH-1:0]   stable_o,
   output logic [WIDTH-1:0]   rise_o,
   output logic [WIDTH-1:0]   fall_o,
   output logic [WIDTH-1:0]   changed_o
`ifdef PIO_COND_GLITCH_CNT_EN
   ,
   output logic [8*WIDTH-1:0] glitch_cnt_o
`endif
);

   localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic          s1_q;
      logic          s2_q;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          stable_q;
      logic          stable_d;
      logic          rise_q;
      logic          rise_d;
      logic          fall_q;
      logic          fall_d;
      logic          changed_q;
      logic          changed_d;
      logic          accept;

      always_comb begin
         cnt_d    = cnt_q;
         stable_d = stable_q;
         rise_d   = 1'b0;
         fall_d   = 1'b0;
         accept   = 1'b0;
         if (s2_q == stable_q) begin
            cnt_d = '0;
         end else if (cnt_q == LAST) begin
            cnt_d    = '0;
            stable_d = s2_q;
            rise_d   = s2_q;
            fall_d   = ~s2_q;
            accept   = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // A new transition outranks a simultaneous clear.
      assign changed_d = accept | (changed_q & ~clr_i);

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            changed_q <= 1'b0;
         end else begin
            s1_q      <= raw_i[i];
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
         end
      end

      assign stable_o[i]  = stable_q;
      assign rise_o[i]    = rise_q;
      assign fall_o[i]    = fall_q;
      assign changed_o[i] = changed_q;

`ifdef PIO_COND_GLITCH_CNT_EN
      logic [7:0] glitch_q;
      logic [7:0] glitch_d;
      logic       glitch;

      // Sync level fell back to the accepted one before the count completed.
      assign glitch = (s2_q == stable_q) && (cnt_q != '0);

      always_comb begin
         glitch_d = glitch_q;
         if (clr_i) begin
            glitch_d = 8'd0;
         end else if (glitch && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
         end
      end

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            glitch_q <= 8'd0;
         end else begin
            glitch_q <= glitch_d;
         end
      end

      assign glitch_cnt_o[8*i +: 8] = glitch_q;
`endif
   end

endmodule

// File: tb/tb_pio_input_conditioner.sv
// tb_pio_input_conditioner: directed + random stimulus against a timestamp-based model.
// Build with PIO_COND_GLITCH_CNT_EN defined to also check glitch counters.
module tb_pio_input_conditioner;
   localparam int W  = 4;
   localparam int DC = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] raw = '0;
   logic         clr = 1'b0;
   logic [W-1:0] stable;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic [W-1:0] changed;
`ifdef PIO_COND_GLITCH_CNT_EN
   logic [8*W-1:0] gcnt;
`endif

   always #5 clk = ~clk;

   pio_input_conditioner #(
      .WIDTH(W),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clk_clk(clk),
      .reset_reset_n(rst_n),
      .raw_i(raw),
      .clr_i(clr),
      .stable_o(stable),
      .rise_o(rise),
      .fall_o(fall),
      .changed_o(changed)
`ifdef PIO_COND_GLITCH_CNT_EN
      ,
      .glitch_cnt_o(gcnt)
`endif
   );

   // Reference model: a new level is accepted once s2 has disagreed with
   // the accepted level for DC consecutive edges (tracked by start timestamp).
   logic [W-1:0] m_s1, m_s2, m_st, m_rise, m_fall, m_chg;
   int           since[W];
   int           m_gl[W];
   int           edge_n;
   int           n_vec;
   int           n_err;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_st = '0;
      m_rise = '0; m_fall = '0; m_chg = '0;
      for (int i = 0; i < W; i++) begin
         since[i] = -1;
         m_gl[i]  = 0;
      end
   endtask

   task automatic model_edge();
      logic [W-1:0] s2;
      bit acc;
      bit gl;
      s2 = m_s2;
      m_rise = '0;
      m_fall = '0;
      edge_n++;
      for (int i = 0; i < W; i++) begin
         acc = 1'b0;
         gl  = 1'b0;
         if (s2[i] == m_st[i]) begin
            gl = (since[i] >= 0);
            since[i] = -1;
         end else begin
            if (since[i] < 0) since[i] = edge_n;
            if (edge_n - since[i] + 1 == DC) begin
               acc = 1'b1;
               m_st[i] = s2[i];
               m_rise[i] = s2[i];
               m_fall[i] = ~s2[i];
               since[i] = -1;
            end
         end
         if (acc) m_chg[i] = 1'b1;
         else if (clr) m_chg[i] = 1'b0;
         if (clr) m_gl[i] = 0;
         else if (gl && m_gl[i] < 255) m_gl[i]++;
      end
      m_s2 = m_s1;
      m_s1 = raw;
   endtask

   task automatic compare_all();
      check("stable", 32'(stable), 32'(m_st));
      check("rise", 32'(rise), 32'(m_rise));
      check("fall", 32'(fall), 32'(m_fall));
      check("changed", 32'(changed), 32'(m_chg));
`ifdef PIO_COND_GLITCH_CNT_EN
      for (int i = 0; i < W; i++)
         check("glitch_cnt", 32'(gcnt[8*i +: 8]), 32'(m_gl[i]));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      #2 rst_n = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      edge_n = 0;
      model_reset();
      #12;
      compare_all();
      rst_n = 1'b1;

      // Idle lines stay quiet
      repeat (20) step();
      check("idle_stable", 32'(stable), 32'd0);
      check("idle_changed", 32'(changed), 32'd0);

      // Channel 0 rise: visible on the 6th edge after first sampling
      raw[0] = 1'b1;
      repeat (5) step();
      check("lat_before", 32'(stable[0]), 32'd0);
      step();
      check("lat_stable", 32'(stable[0]), 32'd1);
      check("lat_rise", 32'(rise), 32'b0001);
      check("lat_changed", 32'(changed[0]), 32'd1);
      step();
      check("rise_one_cycle", 32'(rise), 32'd0);

      // Short pulse on channel 1 is rejected
      raw[1] = 1'b1;
      repeat (3) step();
      raw[1] = 1'b0;
      repeat (8) step();
      check("glitch_stable", 32'(stable[1]), 32'd0);
`ifdef PIO_COND_GLITCH_CNT_EN
      check("glitch_count", 32'(gcnt[15:8]), 32'd1);
`endif

      // Simultaneous rises on channels 1 and 3
      raw[1] = 1'b1;
      raw[3] = 1'b1;
      repeat (5) step();
      check("multi_before", 32'(stable), 32'b0001);
      step();
      check("multi_stable", 32'(stable), 32'b1011);
      check("multi_rise", 32'(rise), 32'b1010);

      // Clear on the same edge as a fall: set wins on channel 0
      raw[0] = 1'b0;
      repeat (5) step();
      clr = 1'b1;
      step();
      check("clr_fall", 32'(fall), 32'b0001);
      check("clr_setwins", 32'(changed), 32'b0001);
      step();
      check("clr_alone", 32'(changed), 32'd0);
      clr = 1'b0;

      // Reset with channel 2 mid-count, then re-debounce from scratch
      raw[2] = 1'b1;
      repeat (5) step();
      do_reset();
      check("rst_stable", 32'(stable), 32'd0);
      check("rst_changed", 32'(changed), 32'd0);
      repeat (5) step();
      check("rst_relat_before", 32'(stable[2]), 32'd0);
      step();
      check("rst_relat_after", 32'(stable), 32'b1110);

      // Random phase: sparse toggles give both glitches and accepts
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(5) == 0) raw[i] = ~raw[i];
         clr = ($urandom_range(7) == 0);
         if ($urandom_range(199) == 0) do_reset();
         step();
      end
      clr = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
